// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of an external ALU.
// Accepts one 16-bit instruction at a time, reads operands from an internal
// 8-entry register file, drives the ALU, captures its result and writes it back.
// Sequence per instruction: IDLE (accept) -> READ -> EXEC -> WB -> IDLE.
`timescale 1ns/1ps
module alu_issue_ctrl #(
    parameter int REGISTER_LEN = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Instr_valid,
    output logic                    Instr_ready,
    input  logic [15:0]             Instr,
    output logic [2:0]              ALU_OP,
    output logic [3:0]              ALU_Cal_value,
    output logic [REGISTER_LEN-1:0] ALU_A,
    output logic [REGISTER_LEN-1:0] ALU_B,
    input  logic [REGISTER_LEN:0]   ALU_R,
    output logic                    Done,
    output logic                    Carry,
    input  logic [2:0]              Dbg_addr,
    output logic [REGISTER_LEN-1:0] Dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_ready;
    logic                    r_done;
    logic                    r_carry;
    logic [2:0]              r_op;
    logic [3:0]              r_cal;
    logic [REGISTER_LEN-1:0] r_a;
    logic [REGISTER_LEN-1:0] r_b;
    logic [REGISTER_LEN-1:0] r_rf [8];
    logic [15:0]             r_instr;
    logic [REGISTER_LEN:0]   r_result;

    logic [2:0]              w_op;
    logic [3:0]              w_cal;
    logic [2:0]              w_rd;
    logic [2:0]              w_ra;
    logic [2:0]              w_rb;
    logic [REGISTER_LEN-1:0] w_rd_a;
    logic [REGISTER_LEN-1:0] w_rd_b;
    logic                    w_accept;

    // Field decode of the latched instruction word.
    assign w_op  = r_instr[15:13];
    assign w_cal = r_instr[12:9];
    assign w_rd  = r_instr[8:6];
    assign w_ra  = r_instr[5:3];
    assign w_rb  = r_instr[2:0];

    // Register 0 is hard-wired to zero on every read port.
    assign w_rd_a   = (w_ra == 3'd0) ? '0 : r_rf[w_ra];
    assign w_rd_b   = (w_rb == 3'd0) ? '0 : r_rf[w_rb];
    assign Dbg_data = (Dbg_addr == 3'd0) ? '0 : r_rf[Dbg_addr];

    assign w_accept = (r_state == S_IDLE) && Instr_valid && r_ready;

    // Sequencer with registered control outputs and register-file write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_carry <= 1'b0;
            r_op    <= '0;
            r_cal   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_op    <= w_op;
                    r_cal   <= w_cal;
                    r_a     <= w_rd_a;
                    r_b     <= w_rd_b;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    // Done is registered so it is high for exactly the WB cycle.
                    r_done  <= 1'b1;
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (w_rd != 3'd0) begin
                        r_rf[w_rd] <= r_result[REGISTER_LEN-1:0];
                    end
                    r_carry <= r_result[REGISTER_LEN];
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath capture: instruction word on accept, ALU result at the end of EXEC.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_instr <= Instr;
        end
        if (r_state == S_EXEC) begin
            r_result <= ALU_R;
        end
    end

    assign Instr_ready   = r_ready;
    assign Done          = r_done;
    assign Carry         = r_carry;
    assign ALU_OP        = r_op;
    assign ALU_Cal_value = r_cal;
    assign ALU_A         = r_a;
    assign ALU_B         = r_b;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: behavioural ALU plus register-file model,
// directed scenarios followed by randomized instruction words.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    localparam int RL = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          Instr_valid = 1'b0;
    logic          Instr_ready;
    logic [15:0]   Instr = '0;
    logic [2:0]    ALU_OP;
    logic [3:0]    ALU_Cal_value;
    logic [RL-1:0] ALU_A;
    logic [RL-1:0] ALU_B;
    logic [RL:0]   ALU_R;
    logic          Done;
    logic          Carry;
    logic [2:0]    Dbg_addr = '0;
    logic [RL-1:0] Dbg_data;

    int  n_checks = 0;
    int  n_errors = 0;
    int  model_rf [8];
    int  model_carry = 0;
    time last_accept = 0;
    bit  prev_b2b = 1'b0;

    alu_issue_ctrl #(.REGISTER_LEN(RL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Instr_valid   (Instr_valid),
        .Instr_ready   (Instr_ready),
        .Instr         (Instr),
        .ALU_OP        (ALU_OP),
        .ALU_Cal_value (ALU_Cal_value),
        .ALU_A         (ALU_A),
        .ALU_B         (ALU_B),
        .ALU_R         (ALU_R),
        .Done          (Done),
        .Carry         (Carry),
        .Dbg_addr      (Dbg_addr),
        .Dbg_data      (Dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU in plain integer arithmetic, truncated to RL+1 bits.
    function automatic int alu_ref(int op, int cal, int a, int b);
        int r;
        case (op)
            0:       r = a;
            1:       r = (a < b) ? 1 : 0;
            2:       r = a + cal;
            3:       r = a - cal;
            4:       r = a + b;
            5:       r = a - b;
            6:       r = a & b;
            default: r = a | b;
        endcase
        return r & ((1 << (RL + 1)) - 1);
    endfunction

    // External combinational ALU driven by the DUT's operand outputs.
    always_comb ALU_R = (RL + 1)'(alu_ref(int'(ALU_OP), int'(ALU_Cal_value), int'(ALU_A), int'(ALU_B)));

    function automatic logic [15:0] mk(int op, int cal, int rd, int ra, int rb);
        return 16'(((op & 7) << 13) | ((cal & 15) << 9) | ((rd & 7) << 6) | ((ra & 7) << 3) | (rb & 7));
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_rf[i] = 0;
        model_carry = 0;
    endtask

    // Issue one instruction from a falling edge and follow it through all four cycles.
    task automatic send(input logic [15:0] w, input bit b2b);
        int  op, cal, rd, ra, rb, ea, eb, er;
        bit  ok;
        op  = (int'(w) >> 13) & 7;
        cal = (int'(w) >> 9) & 15;
        rd  = (int'(w) >> 6) & 7;
        ra  = (int'(w) >> 3) & 7;
        rb  = int'(w) & 7;
        ea  = model_rf[ra];
        eb  = model_rf[rb];
        er  = alu_ref(op, cal, ea, eb);
        Instr       = w;
        Instr_valid = 1'b1;
        Dbg_addr    = 3'(rd);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Instr_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            Instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (prev_b2b) chk("b2b_accept_gap", int'($time - last_accept), 40);
        last_accept = $time;
        prev_b2b    = b2b;
        #1;
        if (!b2b) Instr_valid = 1'b0;
        @(negedge clk);
        chk("read_ready", int'(Instr_ready), 0);
        chk("read_done", int'(Done), 0);
        @(negedge clk);
        chk("exec_op", int'(ALU_OP), op);
        chk("exec_cal", int'(ALU_Cal_value), cal);
        chk("exec_a", int'(ALU_A), ea);
        chk("exec_b", int'(ALU_B), eb);
        chk("exec_alu_r", int'(ALU_R), er);
        chk("exec_ready", int'(Instr_ready), 0);
        chk("exec_done", int'(Done), 0);
        @(negedge clk);
        chk("wb_done", int'(Done), 1);
        chk("wb_ready", int'(Instr_ready), 0);
        chk("wb_carry_held", int'(Carry), model_carry);
        if (rd != 0) model_rf[rd] = er & ((1 << RL) - 1);
        model_carry = (er >> RL) & 1;
        @(negedge clk);
        chk("idle_done", int'(Done), 0);
        chk("idle_ready", int'(Instr_ready), 1);
        chk("carry", int'(Carry), model_carry);
        chk("rf_rd", int'(Dbg_data), model_rf[rd]);
        chk("hold_a", int'(ALU_A), ea);
        chk("hold_op", int'(ALU_OP), op);
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_gap_ready", int'(Instr_ready), 1);
            chk("idle_gap_done", int'(Done), 0);
        end
    endtask

    task automatic check_rf_all();
        for (int i = 0; i < 8; i++) begin
            Dbg_addr = 3'(i);
            #1;
            chk("rf_scan", int'(Dbg_data), model_rf[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        bit          b2b;
        model_reset();

        // Reset state
        #12;
        chk("rst_alu_op", int'(ALU_OP), 0);
        chk("rst_alu_a", int'(ALU_A), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_carry", int'(Carry), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(Instr_ready), 1);
        check_rf_all();

        // Test 1: RF[1]=5, then RF[2]=RF[1]+RF[1]=10
        chk("t1_word", int'(mk(2, 5, 1, 0, 0)), 16'h4A40);
        send(16'h4A40, 1'b0);
        idle_gap(1);
        send(mk(4, 0, 2, 1, 1), 1'b0);
        idle_gap(2);

        // Test 2: 0-1 wraps to 0x7FF, then 0x3FF+1 gives 0 with carry
        send(mk(3, 1, 4, 0, 0), 1'b0);
        send(mk(2, 1, 5, 4, 0), 1'b0);

        // Test 3: writes to register 0 are dropped
        send(mk(2, 7, 0, 0, 0), 1'b0);
        Dbg_addr = 3'd0;
        #1;
        chk("t3_r0_zero", int'(Dbg_data), 0);

        // Test 4: valid held high, back-to-back words, RAW on previous Rd
        send(mk(2, 9, 3, 0, 0), 1'b1);
        send(mk(4, 0, 7, 2, 3), 1'b1);
        send(mk(5, 0, 6, 7, 3), 1'b0);
        idle_gap(1);

        // Test 6: A<B comparison, both orders
        send(mk(1, 0, 1, 1, 2), 1'b0);
        send(mk(1, 0, 0, 2, 1), 1'b0);
        check_rf_all();

        // Randomized words, mixing idle gaps with held-valid streams
        for (int i = 0; i < 40; i++) begin
            w   = 16'($urandom);
            b2b = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            send(w, b2b);
            if (!b2b) idle_gap($urandom_range(0, 2));
        end
        check_rf_all();

        // Test 5: reset during EXEC aborts the instruction
        @(negedge clk);
        Instr       = mk(2, 3, 6, 2, 4);
        Instr_valid = 1'b1;
        @(posedge clk);
        #1;
        Instr_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_alu_op", int'(ALU_OP), 0);
        chk("t5_alu_cal", int'(ALU_Cal_value), 0);
        chk("t5_alu_a", int'(ALU_A), 0);
        chk("t5_alu_b", int'(ALU_B), 0);
        chk("t5_done", int'(Done), 0);
        chk("t5_carry", int'(Carry), 0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_done_in_rst", int'(Done), 0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t5_done_after_rst", int'(Done), 0);
            chk("t5_ready_after_rst", int'(Instr_ready), 1);
        end
        Dbg_addr = 3'd6;
        #1;
        chk("t5_rf6", int'(Dbg_data), 0);
        chk("t5_carry_after", int'(Carry), 0);
        @(negedge clk);
        send(mk(2, 3, 6, 0, 0), 1'b0);
        check_rf_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
